// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_pkg                                                |
// | Description : Shared types, widths and helpers for the APB slave     |
// |               memory region.                                         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_t;

    // True when addr and base agree on every bit above the word index.
    function automatic logic in_region(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input int unsigned           idx_w
    );
        logic [APB_ADDR_W-1:0] mask;
        mask = {APB_ADDR_W{1'b1}} << idx_w;
        return ((addr ^ base) & mask) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_slave_mem_if                                       |
// | Description : APB bus bundle between a master and one slave region.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface apb_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_slave_regfile                                      |
// | Description : Flop-array word memory, one write port, combinational  |
// |               read port, asynchronous clear.                         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module apb_slave_regfile #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 7
) (
    input  wire logic              PCLK,
    input  wire logic              PRESETn,
    input  wire logic              we,
    input  wire logic [IDX_W-1:0]  waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [IDX_W-1:0]  raddr,
    output logic      [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage: cleared on reset, one word written per enabled cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_slave_mem                                          |
// | Description : APB completer with word memory, programmable access    |
// |               wait states and out-of-region error response.          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                IDX_W     = 7,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic        PCLK,
    input  wire logic        PRESETn,
    input  wire logic [3:0]  wait_cfg,
    apb_slave_mem_if.slave   apb
);
    apb_slv_state_t    r_state;
    apb_slv_state_t    w_next;
    logic [3:0]        r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [DATA_W-1:0] r_prdata;
    logic              r_pslverr;

    logic              w_setup;
    logic              w_access;
    logic              w_err_now;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_entry_err;
    logic              w_entry_wr;
    logic              w_mem_we;

    assign w_setup   = apb.PSEL & ~apb.PENABLE;
    assign w_access  = apb.PSEL &  apb.PENABLE;
    assign w_err_now = ~in_region(APB_ADDR_W'(apb.PADDR), APB_ADDR_W'(BASE_ADDR), IDX_W);

    // A zero-wait transfer enters READY straight from IDLE, so the response
    // must be built from the live setup-phase values rather than the latches.
    assign w_rd_idx    = (r_state == IDLE) ? apb.PADDR[IDX_W-1:0] : r_idx;
    assign w_entry_err = (r_state == IDLE) ? w_err_now : r_err;
    assign w_entry_wr  = (r_state == IDLE) ? apb.PWRITE : r_write;

    // Writes commit on the edge closing READY, ahead of the next setup.
    assign w_mem_we = (r_state == READY) & r_write & ~r_err;

    apb_slave_regfile #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (w_mem_we),
        .waddr   (r_idx),
        .wdata   (r_wdata),
        .raddr   (w_rd_idx),
        .rdata   (w_rd_data)
    );

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state: setup starts a transfer, wait count expires, PSEL drop aborts.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_setup) w_next = (wait_cfg == 4'd0) ? READY : WAIT;
            WAIT: begin
                if (!apb.PSEL)                         w_next = IDLE;
                else if (apb.PENABLE && r_cnt == 4'd1) w_next = READY;
            end
            READY:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Setup-phase capture and access-phase wait countdown.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE && w_setup) begin
            r_cnt   <= wait_cfg;
            r_idx   <= apb.PADDR[IDX_W-1:0];
            r_write <= apb.PWRITE;
            r_wdata <= apb.PWDATA;
            r_err   <= w_err_now;
        end else if (r_state == WAIT && w_access && r_cnt != 4'd0) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Response registers: loaded on entry to READY, zero otherwise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if (w_next == READY) begin
            r_pslverr <= w_entry_err;
            r_prdata  <= (!w_entry_wr && !w_entry_err) ? w_rd_data : '0;
        end else begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end
    end

    assign apb.PREADY  = (r_state == READY);
    assign apb.PSLVERR = r_pslverr;
    assign apb.PRDATA  = r_prdata;
endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_apb_slave_mem                                       |
// | Description : Directed self-checking bench for apb_slave_mem.        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_apb_slave_mem;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic [3:0] wait_cfg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_slave_mem #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .IDX_W     (7),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .wait_cfg (wait_cfg),
        .apb      (bus)
    );

    always #5 PCLK = ~PCLK;

    // Count PREADY pulses, sampled mid-cycle.
    always @(negedge PCLK) begin
        if (bus.PREADY === 1'b1) n_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transfer, entered and left at posedge+1.  Access-phase bus
    // values and wait_cfg are scrambled to show the setup latch is used.
    task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wcfg,
                            input logic [31:0] exp_rd, input logic exp_err);
        int  waits;
        bit  done;
        waits = 0;
        done  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        wait_cfg    = wcfg;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = ~addr;
        bus.PWDATA  = ~wdata;
        bus.PWRITE  = ~wr;
        wait_cfg    = 4'hF;
        while (!done) begin
            @(negedge PCLK);
            if (bus.PREADY === 1'b1) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 20) begin
                    chk({tag, "_timeout"}, 32'(waits), 32'(wcfg));
                    return;
                end
                @(posedge PCLK); #1;
            end
        end
        chk({tag, "_waits"}, 32'(waits), 32'(wcfg));
        chk({tag, "_pslverr"}, {31'd0, bus.PSLVERR}, {31'd0, exp_err});
        if (!wr) chk({tag, "_prdata"}, bus.PRDATA, exp_rd);
        @(posedge PCLK); #1;
    endtask

    task automatic bus_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    int p0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn     = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        wait_cfg    = 4'd0;
        #12;
        chk("rst_pready",  {31'd0, bus.PREADY},  32'd0);
        chk("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        chk("rst_prdata",  bus.PRDATA,           32'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Zero-wait write then read.
        apb_xfer("w05", 1'b1, 32'h05, 32'h0000_00AA, 4'd0, 32'h0, 1'b0);
        apb_xfer("r05", 1'b0, 32'h05, 32'h0,         4'd0, 32'h0000_00AA, 1'b0);

        // Wait-state transfers.
        apb_xfer("w10", 1'b1, 32'h10, 32'h0000_00BB, 4'd3, 32'h0, 1'b0);
        apb_xfer("r10", 1'b0, 32'h10, 32'h0,         4'd2, 32'h0000_00BB, 1'b0);

        // Out-of-region access.
        apb_xfer("w1ff", 1'b1, 32'h1FF, 32'h0000_00FF, 4'd0, 32'h0, 1'b1);
        apb_xfer("r7f",  1'b0, 32'h7F,  32'h0,         4'd0, 32'h0, 1'b0);
        apb_xfer("r1ff", 1'b0, 32'h1FF, 32'h0,         4'd1, 32'h0, 1'b1);

        // Back-to-back burst.
        p0 = n_pulses;
        apb_xfer("bw01", 1'b1, 32'h01, 32'h11, 4'd0, 32'h0,  1'b0);
        apb_xfer("br01", 1'b0, 32'h01, 32'h0,  4'd0, 32'h11, 1'b0);
        apb_xfer("bw02", 1'b1, 32'h02, 32'h22, 4'd0, 32'h0,  1'b0);
        apb_xfer("br02", 1'b0, 32'h02, 32'h0,  4'd0, 32'h22, 1'b0);
        apb_xfer("bw03", 1'b1, 32'h03, 32'h33, 4'd0, 32'h0,  1'b0);
        apb_xfer("br03", 1'b0, 32'h03, 32'h0,  4'd0, 32'h33, 1'b0);
        bus_idle();
        chk("burst_pulses", 32'(n_pulses - p0), 32'd6);

        // Abort during WAIT.
        p0 = n_pulses;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 32'h20;
        bus.PWDATA  = 32'h55;
        wait_cfg    = 4'd4;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            chk("abort_wait_pready", {31'd0, bus.PREADY}, 32'd0);
            @(posedge PCLK); #1;
        end
        bus_idle();
        repeat (3) @(posedge PCLK);
        #1;
        chk("abort_pulses", 32'(n_pulses - p0), 32'd0);
        apb_xfer("r20", 1'b0, 32'h20, 32'h0, 4'd0, 32'h0, 1'b0);

        // Reset while READY presents read data: clears asynchronously.
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 32'h10;
        wait_cfg    = 4'd0;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rdy_pready",  {31'd0, bus.PREADY}, 32'd1);
        chk("rdy_prdata",  bus.PRDATA,          32'h0000_00BB);
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_pready", {31'd0, bus.PREADY}, 32'd0);
        chk("arst_prdata", bus.PRDATA,          32'd0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Reset during WAIT of a write to 0x30.
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 32'h30;
        bus.PWDATA  = 32'h77;
        wait_cfg    = 4'd3;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        chk("w30_wait_pready", {31'd0, bus.PREADY}, 32'd0);
        #2 PRESETn = 1'b0;
        #1;
        chk("wrst_pready",  {31'd0, bus.PREADY},  32'd0);
        chk("wrst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        chk("wrst_prdata",  bus.PRDATA,           32'd0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer("r30",      1'b0, 32'h30, 32'h0, 4'd0, 32'h0, 1'b0);
        apb_xfer("r10_post", 1'b0, 32'h10, 32'h0, 4'd1, 32'h0, 1'b0);
        bus_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
